bundle3_fifo_responder: RTL

//  Responder end of the 3-lane bundle interface: requester drives A_0_* (request) and C_0_* (data),

---
 rtl/bundle3_pkg.sv | 6 +
 rtl/bundle3_fifo_mem.sv | 53 +++++
 rtl/bundle3_fifo_responder.sv | 75 +++++++
 3 files changed

// File: rtl/bundle3_pkg.sv
// bundle3_pkg: shared opcode/state types and bundle width for the bundle3 FIFO responder
package bundle3_pkg;
  localparam int BUNDLE_W = 3;
  typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_CLEAR} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT_LOW} state_e;
endpackage

// File: rtl/bundle3_fifo_mem.sv
// bundle3_fifo_mem: DEPTH x BUNDLE_W FIFO storage with pointers, count, pop-data register and flags
module bundle3_fifo_mem
  import bundle3_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic                clr_i,
  input  logic [BUNDLE_W-1:0] wdata_i,
  output logic [BUNDLE_W-1:0] rdata_o,
  output logic                full_o,
  output logic                empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [BUNDLE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0] cnt_q, cnt_d;
  logic [BUNDLE_W-1:0] rdata_q, rdata_d;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (PTR_W+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = rdata_q;
  // next pointers/count; rejected pushes/pops leave everything untouched, clear keeps pop data
  always_comb begin
    wr_d    = clr_i ? '0 : do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = clr_i ? '0 : do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = clr_i ? '0 : do_push ? cnt_q + 1'b1 : do_pop ? cnt_q - 1'b1 : cnt_q;
    rdata_d = do_pop ? mem_q[rd_q] : rdata_q;
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
  // storage array needs no reset: only entries behind the count are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/bundle3_fifo_responder.sv
// bundle3_fifo_responder: 4-phase bundle responder around a small FIFO; BUNDLE3_ERR_EN adds sticky err port
module bundle3_fifo_responder
  import bundle3_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef BUNDLE3_ERR_EN
  output logic err,
`endif
  input  logic A_0_2,
  input  logic A_0_1,
  input  logic A_0_0,
  input  logic C_0_2,
  input  logic C_0_1,
  input  logic C_0_0,
  output logic B_0_2,
  output logic B_0_1,
  output logic B_0_0,
  output logic D_0_2,
  output logic D_0_1,
  output logic D_0_0
);
  state_e state_q, state_d;
  op_e op;
  logic go, push, pop, clr, full, empty;
  logic [BUNDLE_W-1:0] rdata;
  assign op    = op_e'({A_0_1, A_0_0});
  assign go    = state_q == ST_IDLE && A_0_2;
  assign push  = go && op == OP_PUSH;
  assign pop   = go && op == OP_POP;
  assign clr   = go && op == OP_CLEAR;
  assign B_0_2 = state_q == ST_ACK;
  assign B_0_1 = full;
  assign B_0_0 = empty;
  assign {D_0_2, D_0_1, D_0_0} = rdata;
  // handshake sequencing: one-cycle ack, then wait for the requester to release
  always_comb begin
    state_d = state_q;
    state_d = state_q == ST_IDLE ? (A_0_2 ? ST_ACK : ST_IDLE) :
              state_q == ST_ACK  ? ST_WAIT_LOW :
              (A_0_2 ? ST_WAIT_LOW : ST_IDLE);
  end
  // state register; a request still high during reset must be released before it counts
  always_ff @(posedge clk) begin
    if (rst) state_q <= A_0_2 ? ST_WAIT_LOW : ST_IDLE;
    else state_q <= state_d;
  end
`ifdef BUNDLE3_ERR_EN
  logic err_q, err_d;
  assign err = err_q;
  // sticky overflow/underflow flag, cleared only by reset or CLEAR
  always_comb begin
    err_d = err_q;
    err_d = clr ? 1'b0 : err_q | (push && full) | (pop && empty);
  end
  // error register
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
`endif
  bundle3_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (clr),
    .wdata_i ({C_0_2, C_0_1, C_0_0}),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule
